// File: rtl/cordic_pkg.sv
// Shared constants and FSM encoding for the baby_cordic phase sequencer.
// Angles and results are signed Q3.16.
package cordic_pkg;

    localparam int              WIDTH    = 19;
    localparam logic [18:0]     PI_Q     = 19'h3243F;
    localparam logic [18:0]     TWO_PI_Q = 19'h6487E;
    localparam logic [18:0]     PI_2_Q   = 19'h1921F;
    localparam logic [18:0]     CORDIC_K = 19'h09B75;
    localparam int              TIMEOUT  = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_ADVANCE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/cordic_phase_wrap.sv
// Combinational phase update: saturate step to [-pi, +pi], add, wrap into (-pi, pi].
module cordic_phase_wrap #(
    parameter int               WIDTH = cordic_pkg::WIDTH,
    parameter logic [WIDTH-1:0] PI_Q  = cordic_pkg::PI_Q
) (
    input  logic signed [WIDTH-1:0] phase,
    input  logic signed [WIDTH-1:0] step,
    output logic signed [WIDTH-1:0] phase_next
);

    logic signed [WIDTH:0] pi_ext;
    logic signed [WIDTH:0] two_pi_ext;
    logic signed [WIDTH:0] step_ext;
    logic signed [WIDTH:0] step_sat;
    logic signed [WIDTH:0] sum;
    logic signed [WIDTH:0] wrapped;

    assign pi_ext     = $signed({1'b0, PI_Q});
    assign two_pi_ext = pi_ext + pi_ext;
    assign step_ext   = {step[WIDTH-1], step};

    // One extra bit keeps phase + step exact before the wrap pulls it back in range.
    always_comb begin
        step_sat = step_ext;
        if (step_ext > pi_ext)
            step_sat = pi_ext;
        else if (step_ext < -pi_ext)
            step_sat = -pi_ext;

        sum     = {phase[WIDTH-1], phase} + step_sat;
        wrapped = sum;
        if (sum > pi_ext)
            wrapped = sum - two_pi_ext;
        else if (sum <= -pi_ext)
            wrapped = sum + two_pi_ext;
    end

    assign phase_next = wrapped[WIDTH-1:0];

endmodule

// File: rtl/cordic_phase_seq.sv
// NCO-style sequencer for the 12-stage CORDIC core: phase accumulator, start/theta issue,
// result capture into a valid/ack sample register. Optional done watchdog: SEQ_TIMEOUT_EN.
module cordic_phase_seq #(
    parameter int               WIDTH   = cordic_pkg::WIDTH,
    parameter logic [WIDTH-1:0] PI_Q    = cordic_pkg::PI_Q,
    parameter int               TIMEOUT = cordic_pkg::TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    run,
    input  logic signed [WIDTH-1:0] step,
    input  logic                    load_phase,
    input  logic signed [WIDTH-1:0] phase_init,
    input  logic                    cos_sel,
    input  logic                    sample_ack,
    input  logic                    clr_overrun,
    output logic signed [WIDTH-1:0] theta,
    output logic                    start,
    output logic                    cos,
    input  logic                    done,
    input  logic signed [WIDTH-1:0] result,
    output logic signed [WIDTH-1:0] phase,
    output logic signed [WIDTH-1:0] sample,
    output logic                    sample_valid,
    output logic                    overrun,
`ifdef SEQ_TIMEOUT_EN
    output logic                    timeout_err,
`endif
    output logic                    busy
);

    import cordic_pkg::*;

    seq_state_t              state_reg, state_next;
    logic signed [WIDTH-1:0] theta_reg, theta_next;
    logic signed [WIDTH-1:0] phase_reg, phase_next;
    logic signed [WIDTH-1:0] sample_reg, sample_next;
    logic signed [WIDTH-1:0] phase_wrapped;
    logic                    cos_reg, cos_next;
    logic                    start_reg, start_next;
    logic                    busy_reg, busy_next;
    logic                    sample_valid_reg, sample_valid_next;
    logic                    overrun_reg, overrun_next;
    logic                    capture;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic          timeout_err_reg, timeout_err_next;
`endif

    cordic_phase_wrap #(
        .WIDTH (WIDTH),
        .PI_Q  (PI_Q)
    ) u_wrap (
        .phase      (phase_reg),
        .step       (step),
        .phase_next (phase_wrapped)
    );

    always_comb begin
        state_next  = state_reg;
        theta_next  = theta_reg;
        cos_next    = cos_reg;
        start_next  = 1'b0;
        busy_next   = busy_reg;
        phase_next  = phase_reg;
        sample_next = sample_reg;
        capture     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        tmo_cnt_next     = tmo_cnt_reg;
        timeout_err_next = timeout_err_reg;
        if (clr_overrun)
            timeout_err_next = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (run)
                    state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                theta_next = phase_reg;
                cos_next   = cos_sel;
                start_next = 1'b1;
                busy_next  = 1'b1;
                state_next = ST_WAIT;
`ifdef SEQ_TIMEOUT_EN
                tmo_cnt_next = '0;
`endif
            end
            // theta/cos stay untouched here: the core range-reduces theta every cycle.
            ST_WAIT: begin
                if (done) begin
                    capture     = 1'b1;
                    sample_next = result;
                    busy_next   = 1'b0;
                    state_next  = ST_ADVANCE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
                    busy_next        = 1'b0;
                    timeout_err_next = 1'b1;
                    state_next       = ST_ADVANCE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
`endif
            end
            ST_ADVANCE: begin
                phase_next = phase_wrapped;
                state_next = run ? ST_ISSUE : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (load_phase)
            phase_next = phase_init;

        // A capture beats a same-cycle ack, so the fresh sample stays marked unread.
        sample_valid_next = sample_valid_reg;
        if (capture)
            sample_valid_next = 1'b1;
        else if (sample_ack)
            sample_valid_next = 1'b0;

        overrun_next = overrun_reg;
        if (clr_overrun)
            overrun_next = 1'b0;
        if (capture && sample_valid_reg && !sample_ack)
            overrun_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            theta_reg        <= '0;
            cos_reg          <= 1'b0;
            start_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            phase_reg        <= '0;
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo_cnt_reg      <= '0;
            timeout_err_reg  <= 1'b0;
`endif
        end else if (clk_en) begin
            state_reg        <= state_next;
            theta_reg        <= theta_next;
            cos_reg          <= cos_next;
            start_reg        <= start_next;
            busy_reg         <= busy_next;
            phase_reg        <= phase_next;
            sample_reg       <= sample_next;
            sample_valid_reg <= sample_valid_next;
            overrun_reg      <= overrun_next;
`ifdef SEQ_TIMEOUT_EN
            tmo_cnt_reg      <= tmo_cnt_next;
            timeout_err_reg  <= timeout_err_next;
`endif
        end
    end

    assign theta        = theta_reg;
    assign cos          = cos_reg;
    assign start        = start_reg;
    assign busy         = busy_reg;
    assign phase        = phase_reg;
    assign sample       = sample_reg;
    assign sample_valid = sample_valid_reg;
    assign overrun      = overrun_reg;
`ifdef SEQ_TIMEOUT_EN
    assign timeout_err  = timeout_err_reg;
`endif

endmodule

// File: tb/tb_cordic_phase_seq.sv
// Directed bench for cordic_phase_seq with a behavioural 13-cycle core model.
// Build with +define+SEQ_TIMEOUT_EN to also exercise the done watchdog.
module tb_cordic_phase_seq;

    logic        clk = 1'b0;
    logic        rst, clk_en, run, load_phase, cos_sel, sample_ack, clr_overrun;
    logic [18:0] step, phase_init;
    logic [18:0] theta, phase, sample, result;
    logic        start, cos, done, sample_valid, overrun, busy;
`ifdef SEQ_TIMEOUT_EN
    logic        timeout_err;
`endif

    cordic_phase_seq dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .run          (run),
        .step         (step),
        .load_phase   (load_phase),
        .phase_init   (phase_init),
        .cos_sel      (cos_sel),
        .sample_ack   (sample_ack),
        .clr_overrun  (clr_overrun),
        .theta        (theta),
        .start        (start),
        .cos          (cos),
        .done         (done),
        .result       (result),
        .phase        (phase),
        .sample       (sample),
        .sample_valid (sample_valid),
        .overrun      (overrun),
`ifdef SEQ_TIMEOUT_EN
        .timeout_err  (timeout_err),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Core model: done rises 13 clk_en edges after the start edge; never reset by rst.
    logic        core_done   = 1'b0;
    logic [18:0] core_result = '0;
    int          core_cnt    = 0;
    bit          core_mute   = 1'b0;

    function automatic logic [18:0] core_f(logic [18:0] th, logic c);
        if (c && th == 19'h00000)   return 19'h10000;
        if (!c && th == 19'h00000)  return 19'h00000;
        if (!c && th == 19'h1921F)  return 19'h10000;
        if (!c && th == 19'h66DE1)  return 19'h70000;
        return th ^ 19'h2AAAA;
    endfunction

    always @(posedge clk) begin
        if (clk_en) begin
            if (start)
                core_cnt <= 12;
            else if (core_cnt > 0)
                core_cnt <= core_cnt - 1;
            core_done <= (!start && core_cnt == 1 && !core_mute);
            if (!start && core_cnt == 1)
                core_result <= core_f(theta, cos);
        end
    end

    assign done   = core_done;
    assign result = core_result;

    int total = 0;
    int bad   = 0;
    bit toggle_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (toggle_en)
            clk_en = ~clk_en;
    endtask

    task automatic wait_valid(string name, int budget);
        int n = 0;
        while (!sample_valid && n < budget) begin
            tick();
            n++;
        end
        if (!sample_valid) begin
            total++;
            bad++;
            $display("FAIL %s: no capture within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_done(string name, int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic ack_sample();
        tick(); sample_ack = 1'b1;
        tick(); tick();
        sample_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        tick(); clr_overrun = 1'b1;
        tick(); tick();
        clr_overrun = 1'b0;
    endtask

    // One conversion with run dropped mid-flight; checks hold, capture and the phase update.
    task automatic run_one(string name, logic [18:0] init, logic [18:0] stp, logic c,
                           logic [18:0] exp_sample, logic [18:0] exp_phase);
        int n = 0;
        bit stable = 1'b1;
        tick(); load_phase = 1'b1; phase_init = init; step = stp; cos_sel = c; run = 1'b0;
        tick(); tick(); load_phase = 1'b0; run = 1'b1;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        run = 1'b0;
        n = 0;
        while (!sample_valid && n < 200) begin
            if (busy && (theta !== init || cos !== c))
                stable = 1'b0;
            tick();
            n++;
        end
        wait_valid({name, "_cap"}, 1);
        repeat (4) tick();
        chk({name, "_hold"}, 32'(stable), 32'd1);
        chk({name, "_theta"}, 32'(theta), 32'(init));
        chk({name, "_cos"}, 32'(cos), 32'(c));
        chk({name, "_sample"}, 32'(sample), 32'(exp_sample));
        chk({name, "_phase"}, 32'(phase), 32'(exp_phase));
        ack_sample();
    endtask

    typedef struct {
        logic [18:0] init;
        logic [18:0] stp;
        logic        c;
        logic [18:0] exp_sample;
        logic [18:0] exp_phase;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, s1, s2, d1, n;
        bit prev_start, seen_done;

        vecs[0] = '{19'h00000, 19'h1921F, 1'b0, 19'h00000, 19'h1921F};
        vecs[1] = '{19'h1921F, 19'h1921F, 1'b0, 19'h10000, 19'h3243E};
        vecs[2] = '{19'h3243E, 19'h1921F, 1'b0, 19'h18E94, 19'h66DDF};
        vecs[3] = '{19'h66DE1, 19'h1921F, 1'b0, 19'h70000, 19'h00000};
        vecs[4] = '{19'h00000, 19'h3FFFF, 1'b0, 19'h00000, 19'h3243F};
        vecs[5] = '{19'h3243F, 19'h3FFFF, 1'b0, 19'h18E95, 19'h00000};
        vecs[6] = '{19'h00000, 19'h40000, 1'b0, 19'h00000, 19'h3243F};
        vecs[7] = '{19'h4DBC2, 19'h70000, 1'b0, 19'h67168, 19'h22440};
        vecs[8] = '{19'h00000, 19'h00000, 1'b1, 19'h10000, 19'h00000};
        vecs[9] = '{19'h1921F, 19'h00000, 1'b1, 19'h338B5, 19'h1921F};

        rst = 1'b1; clk_en = 1'b1; run = 1'b0; load_phase = 1'b0; cos_sel = 1'b0;
        sample_ack = 1'b0; clr_overrun = 1'b0; step = '0; phase_init = '0;
        repeat (3) tick();
        chk("rst_theta", 32'(theta), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_cos", 32'(cos), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef SEQ_TIMEOUT_EN
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif
        rst = 1'b0;

        // Latency and start-to-start period with clk_en held high.
        tick(); cos_sel = 1'b1; step = '0; run = 1'b1;
        cyc = 0; s1 = -1; s2 = -1; d1 = -1; prev_start = 1'b0;
        while (s2 < 0 && cyc < 100) begin
            tick();
            cyc++;
            if (start && !prev_start) begin
                if (s1 < 0) s1 = cyc;
                else        s2 = cyc;
            end
            if (done && d1 < 0)
                d1 = cyc;
            prev_start = start;
        end
        run = 1'b0;
        chk("latency", 32'(d1 - s1), 32'd13);
        chk("period", 32'(s2 - s1), 32'd16);
        chk("first_sample", 32'(sample), 32'h10000);
        chk("first_valid", 32'(sample_valid), 32'd1);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        repeat (3) tick();
        ack_sample();
        pulse_clr();

        for (int i = 0; i < 10; i++)
            run_one($sformatf("vec%0d", i), vecs[i].init, vecs[i].stp, vecs[i].c,
                    vecs[i].exp_sample, vecs[i].exp_phase);

        // Two captures unread -> overrun; then capture with same-cycle ack -> no overrun.
        tick(); load_phase = 1'b1; phase_init = '0; step = 19'h1921F; cos_sel = 1'b0;
        tick(); load_phase = 1'b0; run = 1'b1;
        wait_valid("ovr_first", 60);
        chk("ovr_before", 32'(overrun), 32'd0);
        wait_done("ovr_second", 40);
        tick();
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_latest", 32'(sample), 32'h10000);
        pulse_clr();
        chk("ovr_clr", 32'(overrun), 32'd0);
        wait_done("ovr_third", 40);
        sample_ack = 1'b1;
        tick();
        sample_ack = 1'b0; run = 1'b0;
        chk("ack_cap_overrun", 32'(overrun), 32'd0);
        chk("ack_cap_valid", 32'(sample_valid), 32'd1);
        chk("ack_cap_sample", 32'(sample), 32'h18E94);
        repeat (4) tick();
        ack_sample();

        // 50% clk_en: same results as the full-rate run.
        toggle_en = 1'b1;
        run_one("tog_a", 19'h1921F, 19'h00000, 1'b0, 19'h10000, 19'h1921F);
        run_one("tog_b", 19'h3243E, 19'h1921F, 1'b0, 19'h18E94, 19'h66DDF);

        // Reset in the middle of WAIT; the late done must be ignored.
        tick(); load_phase = 1'b1; phase_init = 19'h1921F; cos_sel = 1'b1;
        tick(); tick(); load_phase = 1'b0; run = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        repeat (6) tick();
        rst = 1'b1; run = 1'b0;
        tick(); tick();
        chk("mid_rst_theta", 32'(theta), 32'd0);
        chk("mid_rst_cos", 32'(cos), 32'd0);
        chk("mid_rst_phase", 32'(phase), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_start", 32'(start), 32'd0);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("late_done_seen", 32'(seen_done), 32'd1);
        chk("late_done_valid", 32'(sample_valid), 32'd0);
        chk("late_done_sample", 32'(sample), 32'd0);
        chk("late_done_busy", 32'(busy), 32'd0);
        toggle_en = 1'b0;
        clk_en = 1'b1;

`ifdef SEQ_TIMEOUT_EN
        // Done never arrives: watchdog ends WAIT after TIMEOUT cycles, no capture.
        core_mute = 1'b1;
        tick(); load_phase = 1'b1; phase_init = '0; step = 19'h1921F; cos_sel = 1'b0;
        tick(); load_phase = 1'b0; run = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        run = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk("tmo_wait_cycles", 32'(n), 32'd31);
        chk("tmo_err", 32'(timeout_err), 32'd1);
        chk("tmo_no_capture", 32'(sample_valid), 32'd0);
        repeat (3) tick();
        chk("tmo_phase", 32'(phase), 32'h1921F);
        pulse_clr();
        chk("tmo_err_clr", 32'(timeout_err), 32'd0);
        core_mute = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
